// File: rtl/tbd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tbd_pkg
// Description : Shared types and constants for the Sobel SRAM read bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package tbd_pkg;

    // OBI bus geometry
    localparam int OBI_AW  = 32;
    localparam int OBI_DW  = 32;
    localparam int OBI_BEW = 4;

    // Full-word byte enable used for every read
    localparam logic [OBI_BEW-1:0] OBI_BE_FULL = 4'b1111;

    // Default accelerator base address in the shared SRAM map
    localparam logic [OBI_AW-1:0] BASE_ADDR = 32'h1000_0000;

    // Bridge control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } bridge_state_e;

    // Little-endian byte extraction: lane 0 is bits [7:0]
    function automatic logic [7:0] lane_sel(input logic [OBI_DW-1:0] word,
                                            input logic [1:0]        lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tbd_sram_rd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tbd_sram_rd_bridge
// Description : Byte-wide pulse read requests to word-aligned OBI manager
//               reads, with a one-word line buffer and a one-entry pending
//               request slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tbd_sram_rd_bridge
    import tbd_pkg::*;
#(
    parameter bit USE_LINE_BUF = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              acc_req,
    input  logic [31:0]       acc_addr,
    output logic [7:0]        acc_rdata,
    output logic              acc_rvalid,
    output logic              obi_req,
    input  logic              obi_gnt,
    output logic [31:0]       obi_addr,
    output logic              obi_we,
    output logic [3:0]        obi_be,
    input  logic              obi_rvalid,
    input  logic [31:0]       obi_rdata,
    input  logic              obi_err,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  miss_cnt
);

    bridge_state_e      r_state;
    bridge_state_e      w_state_nxt;

    logic [OBI_AW-1:0]  r_addr;        // address of the transaction in flight
    logic               r_buf_valid;
    logic [29:0]        r_buf_tag;
    logic [OBI_DW-1:0]  r_buf_data;
    logic               r_pend_valid;
    logic [31:0]        r_pend_addr;
    logic               r_rvalid;
    logic [7:0]         r_rdata;
    logic               r_err;
    logic [CNT_W-1:0]   r_miss_cnt;

    logic               w_idle;
    logic               w_pend_drain;
    logic               w_req_go;
    logic [31:0]        w_req_addr;
    logic               w_hit;
    logic               w_miss_start;
    logic               w_store_pend;
    logic               w_overflow;
    logic               w_resp_done;

    // In IDLE the pending request has priority; a fresh request arriving in
    // the same cycle is parked in the slot that is being freed.
    assign w_idle       = (r_state == ST_IDLE);
    assign w_pend_drain = w_idle && r_pend_valid;
    assign w_req_go     = w_idle && (r_pend_valid || acc_req);
    assign w_req_addr   = r_pend_valid ? r_pend_addr : acc_addr;
    // A flush in the same cycle forces a miss even if the tag matches
    assign w_hit        = USE_LINE_BUF && r_buf_valid && !flush &&
                          (w_req_addr[31:2] == r_buf_tag);
    assign w_store_pend = acc_req && ((!w_idle && !r_pend_valid) || w_pend_drain);
    assign w_overflow   = acc_req && !w_idle && r_pend_valid;
    assign w_resp_done  = (r_state == ST_RESP) && obi_rvalid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and miss detection
    always_comb begin
        w_state_nxt  = r_state;
        w_miss_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_go && !w_hit) begin
                    w_state_nxt  = ST_REQ;
                    w_miss_start = 1'b1;
                end
            end
            ST_REQ: begin
                if (obi_gnt) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (obi_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Response pulse, returned byte and latched transaction address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 8'h00;
            r_addr   <= '0;
        end else begin
            r_rvalid <= 1'b0;
            if (w_req_go) begin
                if (w_hit) begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= lane_sel(r_buf_data, w_req_addr[1:0]);
                end else begin
                    r_addr <= w_req_addr;
                end
            end
            if (w_resp_done) begin
                r_rvalid <= 1'b1;
                r_rdata  <= obi_err ? 8'h00 : lane_sel(obi_rdata, r_addr[1:0]);
            end
        end
    end

    // One-entry pending request slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
        end else if (w_store_pend) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= acc_addr;
        end else if (w_pend_drain) begin
            r_pend_valid <= 1'b0;
        end
    end

    // Line buffer: filled only by clean responses not overlapped by a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
        end else if (flush) begin
            r_buf_valid <= 1'b0;
        end else if (w_resp_done && !obi_err && USE_LINE_BUF) begin
            r_buf_valid <= 1'b1;
            r_buf_tag   <= r_addr[31:2];
            r_buf_data  <= obi_rdata;
        end
    end

    // Sticky error and saturating miss counter; a new event beats a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_miss_cnt <= '0;
        end else begin
            if (w_overflow || (w_resp_done && obi_err)) begin
                r_err <= 1'b1;
            end else if (flush) begin
                r_err <= 1'b0;
            end

            if (w_miss_start) begin
                if (flush) begin
                    r_miss_cnt <= CNT_W'(1);
                end else if (r_miss_cnt != {CNT_W{1'b1}}) begin
                    r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                end
            end else if (flush) begin
                r_miss_cnt <= '0;
            end
        end
    end

    assign acc_rvalid = r_rvalid;
    assign acc_rdata  = r_rdata;
    assign obi_req    = (r_state == ST_REQ);
    assign obi_addr   = {r_addr[31:2], 2'b00};
    assign obi_we     = 1'b0;
    assign obi_be     = OBI_BE_FULL;
    assign busy       = !w_idle || r_pend_valid;
    assign err        = r_err;
    assign miss_cnt   = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tbd_sram_rd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_tbd_sram_rd_bridge
// Description : Directed self-checking bench for tbd_sram_rd_bridge with an
//               OBI subordinate model and an in-order expected-byte queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tbd_sram_rd_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        acc_req = 1'b0;
    logic [31:0] acc_addr = '0;
    logic [7:0]  acc_rdata;
    logic        acc_rvalid;
    logic        obi_req;
    logic        obi_gnt = 1'b0;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic        obi_rvalid = 1'b0;
    logic [31:0] obi_rdata = '0;
    logic        obi_err = 1'b0;
    logic        busy;
    logic        err;
    logic [15:0] miss_cnt;

    tbd_sram_rd_bridge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .acc_req    (acc_req),
        .acc_addr   (acc_addr),
        .acc_rdata  (acc_rdata),
        .acc_rvalid (acc_rvalid),
        .obi_req    (obi_req),
        .obi_gnt    (obi_gnt),
        .obi_addr   (obi_addr),
        .obi_we     (obi_we),
        .obi_be     (obi_be),
        .obi_rvalid (obi_rvalid),
        .obi_rdata  (obi_rdata),
        .obi_err    (obi_err),
        .busy       (busy),
        .err        (err),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];
    int          rv_cnt = 0;
    int          last_rv_cyc = 0;
    logic [7:0]  last_rdata = 8'h00;
    int          n_xfer = 0;
    int          n_req_cyc = 0;
    logic [31:0] last_obi_addr = '0;
    int          stall_cfg = 0;
    logic [31:0] bad_word = 32'h1000_0010;
    int          t_req = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM contents: word at 0x1000_0000 + 4k holds 0x44332211 + k*0x04040404
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] k;
        k = (a - 32'h1000_0000) >> 2;
        return 32'h4433_2211 + k * 32'h0404_0404;
    endfunction

    // Byte the accelerator must see: errored words always read as zero
    function automatic logic [7:0] exp_byte(input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] s;
        w = mem_word({a[31:2], 2'b00});
        if ({a[31:2], 2'b00} == bad_word) return 8'h00;
        s = w >> (8 * a[1:0]);
        return s[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // OBI subordinate: configurable grant stall, response one cycle after grant
    initial begin : g_obi_sub
        bit          hs;
        bit          req_seen;
        int          stall_left;
        logic [31:0] haddr;
        hs = 0; req_seen = 0; stall_left = 0; haddr = '0;
        forever begin
            @(negedge clk);
            hs = rst_n && obi_req && obi_gnt;
            if (hs) haddr = obi_addr;
            @(posedge clk); #1;
            obi_rvalid = 1'b0;
            obi_err    = 1'b0;
            obi_rdata  = '0;
            if (!rst_n) begin
                req_seen = 0;
                obi_gnt  = 1'b0;
            end else begin
                if (hs) begin
                    obi_rvalid = 1'b1;
                    obi_rdata  = mem_word(haddr);
                    obi_err    = (haddr == bad_word);
                    n_xfer++;
                    req_seen = 0;
                end
                if (obi_req) begin
                    if (!req_seen) begin
                        req_seen   = 1;
                        stall_left = stall_cfg;
                    end
                    if (stall_left > 0) begin
                        obi_gnt = 1'b0;
                        stall_left--;
                    end else begin
                        obi_gnt = 1'b1;
                    end
                end else begin
                    obi_gnt = 1'b0;
                end
            end
        end
    end

    // Per-cycle checker: OBI protocol and in-order response data
    bit          prev_wait = 0;
    logic [31:0] prev_addr = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("obi_we", {31'b0, obi_we}, 32'd0);
            chk("obi_be", {28'b0, obi_be}, 32'hF);
            if (obi_req) begin
                n_req_cyc++;
                last_obi_addr = obi_addr;
                chk("obi_align", {30'b0, obi_addr[1:0]}, 32'd0);
            end
            if (prev_wait) begin
                chk("req_hold", {31'b0, obi_req}, 32'd1);
                chk("addr_hold", obi_addr, prev_addr);
            end
            prev_wait = obi_req && !obi_gnt;
            prev_addr = obi_addr;
            if (acc_rvalid) begin
                rv_cnt++;
                last_rv_cyc = cyc;
                last_rdata  = acc_rdata;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_rvalid: got %h want none", acc_rdata);
                end else begin
                    chk("rdata", {24'b0, acc_rdata}, {24'b0, exp_q.pop_front()});
                end
            end
        end else begin
            prev_wait = 0;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // One-cycle request pulse; caller is aligned just after a rising edge
    task automatic send(input logic [31:0] a, input bit accepted);
        acc_req  = 1'b1;
        acc_addr = a;
        t_req    = cyc;
        if (accepted) exp_q.push_back(exp_byte(a));
        step();
        acc_req = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk); #1;
            if (!busy && exp_q.size() == 0 && !acc_rvalid) done = 1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_timeout: got busy=%0d pending=%0d want idle", name, busy, exp_q.size());
        end
        step();
    endtask

    initial begin : g_main
        int rv0;
        int x0;
        int r0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, obi_req}, 32'd0);
        chk("rst_rvalid", {31'b0, acc_rvalid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_misscnt", {16'b0, miss_cnt}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Miss then hit
        send(32'h1000_0000, 1);
        wait_idle("miss1");
        chk("miss_lat", last_rv_cyc - t_req, 32'd3);
        chk("miss_byte", {24'b0, last_rdata}, 32'h11);
        chk("miss_cnt1", {16'b0, miss_cnt}, 32'd1);
        x0 = n_xfer;
        send(32'h1000_0003, 1);
        wait_idle("hit1");
        chk("hit_lat", last_rv_cyc - t_req, 32'd1);
        chk("hit_byte", {24'b0, last_rdata}, 32'h44);
        chk("hit_cnt", {16'b0, miss_cnt}, 32'd1);
        chk("hit_noxfer", n_xfer - x0, 32'd0);

        // Grant stall of five cycles
        stall_cfg = 5;
        rv0 = rv_cnt; x0 = n_xfer; r0 = n_req_cyc;
        send(32'h1000_0004, 1);
        wait_idle("stall");
        stall_cfg = 0;
        chk("stall_reqcyc", n_req_cyc - r0, 32'd6);
        chk("stall_addr", last_obi_addr, 32'h1000_0004);
        chk("stall_xfer", n_xfer - x0, 32'd1);
        chk("stall_rv", rv_cnt - rv0, 32'd1);

        // Pending request, then overflow while the slot is full
        do_flush();
        @(negedge clk);
        chk("flush_cnt", {16'b0, miss_cnt}, 32'd0);
        step();
        rv0 = rv_cnt;
        send(32'h1000_0008, 1);
        send(32'h1000_0001, 1);
        send(32'h1000_0002, 0);
        wait_idle("pend");
        chk("pend_rv", rv_cnt - rv0, 32'd2);
        chk("pend_byte", {24'b0, last_rdata}, 32'h22);
        chk("pend_cnt", {16'b0, miss_cnt}, 32'd2);
        chk("ovf_err", {31'b0, err}, 32'd1);

        // OBI error response is not cached
        do_flush();
        chk("flush_err", {31'b0, err}, 32'd0);
        rv0 = rv_cnt; x0 = n_xfer;
        send(32'h1000_0012, 1);
        wait_idle("oerr");
        chk("oerr_byte", {24'b0, last_rdata}, 32'h00);
        chk("oerr_err", {31'b0, err}, 32'd1);
        send(32'h1000_0012, 1);
        wait_idle("oerr_retry");
        chk("oerr_xfer", n_xfer - x0, 32'd2);
        chk("oerr_rv", rv_cnt - rv0, 32'd2);

        // Flush in the response cycle: delivered but not cached
        do_flush();
        rv0 = rv_cnt; x0 = n_xfer;
        send(32'h1000_0014, 1);
        step();
        do_flush();
        wait_idle("fresp");
        chk("fresp_rv", rv_cnt - rv0, 32'd1);
        chk("fresp_cnt0", {16'b0, miss_cnt}, 32'd0);
        send(32'h1000_0015, 1);
        wait_idle("fresp_re");
        chk("fresp_cnt1", {16'b0, miss_cnt}, 32'd1);
        chk("fresp_xfer", n_xfer - x0, 32'd2);

        // Asynchronous reset in the middle of a stalled request
        send(32'h1000_0018, 1);
        wait_idle("pre_rst_fill");
        send(32'h1000_0010, 1);
        wait_idle("pre_rst_err");
        stall_cfg = 10;
        send(32'h1000_001C, 1);
        step();
        @(negedge clk);
        chk("pre_rst_req", {31'b0, obi_req}, 32'd1);
        chk("pre_rst_err", {31'b0, err}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'b0, obi_req}, 32'd0);
        chk("arst_rvalid", {31'b0, acc_rvalid}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_err", {31'b0, err}, 32'd0);
        chk("arst_cnt", {16'b0, miss_cnt}, 32'd0);
        exp_q.delete();
        stall_cfg = 0;
        step();
        step();
        rst_n = 1'b1;
        step();
        x0 = n_xfer;
        send(32'h1000_0018, 1);
        wait_idle("post_rst");
        chk("post_rst_xfer", n_xfer - x0, 32'd1);
        chk("post_rst_cnt", {16'b0, miss_cnt}, 32'd1);
        chk("post_rst_lat", last_rv_cyc - t_req, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
